avalon_mem_master: RTL and testbench
====================================

// Module: avalon_mem_master
// PURPOSE
//   Avalon-MM initiator for the MIPS CPU. It takes word requests from two CPU-side clients,
//   instruction fetch (read-only) and data load/store. It arbitrates between them and runs
//   one Avalon read or write at a time against the memory responder. It honours waitrequest
//   and captures readdata with a fixed read latency of 1 cycle.
//   It also returns the result to the granted client with a one-cycle ack pulse.
// PARAMETERS
//   TIMEOUT  256  max consecutive waitrequest-high cycles in BUS before abort; 0 = never abort
// PORTS
//   clk              in   1   system clock, all state on rising edge
//   reset            in   1   asynchronous, active-high reset
//   i_req            in   1   instr fetch request; held with stable i_addr until i_ack
//   i_addr           in   32  instr byte address
//   i_ack            out  1   one-cycle pulse: i_rdata/i_err valid
//   i_rdata          out  32  fetched word
//   i_err            out  1   fetch aborted by timeout
//   d_req            in   1   data request; held with stable payload until d_ack
//   d_write          in   1   1 = store, 0 = load
//   d_addr           in   32  data byte address
//   d_byteenable     in   4   lane enables, passed to bus unchanged
//   d_wdata          in   32  store data
//   d_ack            out  1   one-cycle pulse: d_rdata/d_err valid
//   d_rdata          out  32  loaded word (0 for stores)
//   d_err            out  1   access aborted by timeout
//   avm_address      out  32  {addr[31:2],2'b00}
//   avm_byteenable   out  4   4'b1111 for fetch, d_byteenable for data
//   avm_read         out  1   read strobe
//   avm_write        out  1   write strobe
//   avm_writedata    out  32  store data
//   avm_waitrequest  in   1   responder stall
//   avm_readdata     in   32  valid exactly 1 cycle after read acceptance
//   busy             out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset
//   - Asynchronous reset sets FSM=IDLE, every output 0, timeout counter 0, last_grant=INSTR.
//   - The next contended grant after reset goes to data.
//   - Reset mid-transaction drops avm_read/avm_write at once. No ack is issued for the lost request.
//   Outputs and bus rules
//   - All outputs are registered. No combinational path from inputs to outputs.
//   - Bus signals are latched when the request is granted. They are held stable while waitrequest=1.
//   - A bus transfer is accepted on an edge where (avm_read|avm_write)=1 and avm_waitrequest=0.
//   - Never assert avm_read and avm_write together.
//   FSM states: IDLE, BUS, RDATA, DONE
//   - IDLE: sample i_req and d_req. If both are high, data wins unless last_grant==DATA; then instr wins.
//     Both pending therefore alternates. Update last_grant and go to BUS with the strobe driven.
//   - BUS: on acceptance, drop the strobe. A read goes to RDATA; a write goes to DONE.
//     While waitrequest=1, the counter increments. When count reaches TIMEOUT (TIMEOUT!=0),
//     drop the strobe and go to DONE with err=1 and rdata=0.
//   - RDATA: register avm_readdata into the granted client's rdata. Go to DONE.
//   - DONE: the granted client's ack=1 for exactly this cycle, then return to IDLE.
//     Requests are never sampled in DONE, so a held req cannot be re-granted.
//     The client must drop or renew req on the edge that ends DONE.
//   - The timeout counter clears on leaving BUS.
//   Latency (req sampled in IDLE in cycle 0, no stalls)
//   - Read: strobe in cycle 1, ack in cycle 3.
//   - Write: strobe in cycle 1, ack in cycle 2.
//   - Each waitrequest cycle adds 1 cycle of latency.
//   Data rules
//   - Instr port is read-only.
//   - avm_readdata is passed through unchanged; no byte swap or lane masking.
//   - Address bits [1:0] are discarded on the bus.
//   - The non-granted client's ack/rdata/err stay 0 / hold their previous value.
// TESTING
//   1 Fetch i_addr=32'hBFC00004, waitrequest=0, readdata=32'h2402000A
//     -> avm_read in cycle 1 only; i_ack in cycle 3 with i_rdata=32'h2402000A.
//   2 Store d_addr=32'h00000013, be=4'b0011, wdata=32'hDEADBEEF, waitrequest high for 3 cycles
//     -> address 32'h00000010 with bus signals stable through the stall; d_ack 5 cycles after grant.
//   3 i_req and d_req both held high for 4 transactions -> grant order D,I,D,I; no request lost or duplicated.
//   4 TIMEOUT=4, waitrequest stuck at 1 -> strobe drops after 4 stall cycles;
//     ack with err=1 and rdata=0; FSM back in IDLE.
//   5 reset pulsed in BUS -> avm_read=0 immediately; no ack; next request completes normally.

Source files
------------

// File: rtl/avalon_mem_master.sv
// Avalon-MM initiator: arbitrates instr-fetch and data clients onto one memory port, one transfer at a time.
// Latency: read ack 3 cycles after the request is sampled, write ack 2 cycles; each waitrequest cycle adds 1.
// Backpressure: bus signals are held while avm_waitrequest=1; after TIMEOUT stall cycles the access aborts with err.
module avalon_mem_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  // Counter only needs to reach TIMEOUT-1; the abort fires on the stall that would make it TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [1:0]    state;
  logic          last_grant;  // also identifies the client owning the current transfer
  logic          cur_read;
  logic [CW-1:0] wait_cnt;
  logic          grant_data;

  // Word-aligned bus: the byte-offset bits of both request addresses are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // Data wins a tie unless it had the previous grant, so contention alternates.
  always_comb begin
    grant_data = d_req && (!i_req || (last_grant == GRANT_INSTR));
  end

  // Transaction FSM; every output is a flop updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      last_grant     <= GRANT_INSTR;
      cur_read       <= 1'b0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      i_ack          <= 1'b0;
      i_rdata        <= '0;
      i_err          <= 1'b0;
      d_ack          <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            state      <= S_BUS;
            busy       <= 1'b1;
            last_grant <= grant_data;
            if (grant_data) begin
              avm_address    <= {d_addr[31:2], 2'b00};
              avm_byteenable <= d_byteenable;
              avm_read       <= !d_write;
              avm_write      <= d_write;
              avm_writedata  <= d_write ? d_wdata : 32'h0;
              cur_read       <= !d_write;
            end else begin
              avm_address    <= {i_addr[31:2], 2'b00};
              avm_byteenable <= 4'b1111;
              avm_read       <= 1'b1;
              avm_write      <= 1'b0;
              avm_writedata  <= 32'h0;
              cur_read       <= 1'b1;
            end
          end
        end

        S_BUS: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            wait_cnt  <= '0;
            if (cur_read) begin
              state <= S_RDATA;
            end else begin
              // Only the data client can write; a store returns zero data.
              state   <= S_DONE;
              d_ack   <= 1'b1;
              d_rdata <= 32'h0;
              d_err   <= 1'b0;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_DONE;
            if (last_grant == GRANT_DATA) begin
              d_ack   <= 1'b1;
              d_rdata <= 32'h0;
              d_err   <= 1'b1;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= 32'h0;
              i_err   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        S_RDATA: begin
          // Responder drives readdata exactly one cycle after acceptance, i.e. now.
          state <= S_DONE;
          if (last_grant == GRANT_DATA) begin
            d_ack   <= 1'b1;
            d_rdata <= avm_readdata;
            d_err   <= 1'b0;
          end else begin
            i_ack   <= 1'b1;
            i_rdata <= avm_readdata;
            i_err   <= 1'b0;
          end
        end

        default: begin
          // DONE: ack pulse ends here; requests are not looked at this cycle.
          state <= S_IDLE;
          busy  <= 1'b0;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Bench for avalon_mem_master: responder model with programmable stalls and a result scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task performs its own comparisons.
module tb_avalon_mem_master;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cfg_stall = 0;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  avalon_mem_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_byteenable(d_byteenable),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents as seen on the word-aligned bus address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00004) return 32'h2402000A;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  // Responder: stalls each transfer for cfg_stall cycles, returns readdata one cycle after acceptance.
  initial begin : responder
    int          stall_left;
    logic        in_xfer;
    logic        rd_pend;
    logic [31:0] rd_addr;
    stall_left = 0;
    in_xfer = 1'b0;
    rd_pend = 1'b0;
    rd_addr = 32'h0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0BADF00D;
    forever begin
      @(negedge clk);
      avm_readdata = rd_pend ? mem_word(rd_addr) : 32'h0BADF00D;
      rd_pend = 1'b0;
      if (avm_read || avm_write) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          stall_left = cfg_stall;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          in_xfer = 1'b0;
          rd_pend = avm_read;
          rd_addr = avm_address;
        end
      end else begin
        in_xfer = 1'b0;
        avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_byteenable = 4'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({i_ack, i_err, d_ack, d_err, avm_read, avm_write, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {i_ack, i_err, d_ack, d_err, avm_read, avm_write, busy});
    end
    vectors++;
    if ({avm_address, avm_byteenable, avm_writedata, i_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h be=%h wd=%h ird=%h drd=%h, want all 0",
               avm_address, avm_byteenable, avm_writedata, i_rdata, d_rdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_fetch();
    logic [7:0] rd_trace;
    int ack_cyc;
    int ack_n;
    exp_t e;
    rd_trace = '0; ack_cyc = -1; ack_n = 0;
    cfg_stall = 0;
    i_addr = 32'hBFC00004;
    i_req = 1'b1;
    sb.push_back('{1'b0, 32'h2402000A, 1'b0});
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      rd_trace[c] = avm_read;
      if (avm_read) begin
        vectors++;
        if (avm_address !== 32'hBFC00004 || avm_byteenable !== 4'hF || avm_write !== 1'b0) begin
          miscompares++;
          $display("FAIL fetch_bus: addr=%h be=%h wr=%b, want bfc00004 f 0", avm_address, avm_byteenable, avm_write);
        end
      end
      if (i_ack || d_ack) begin
        ack_n++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          i_req = 1'b0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (d_ack !== 1'b0 || i_rdata !== e.rdata || i_err !== e.err) begin
              miscompares++;
              $display("FAIL fetch_result: d_ack=%b rdata=%h err=%b, want 0 %h %b", d_ack, i_rdata, i_err, e.rdata, e.err);
            end
          end
        end
      end
    end
    if (ack_cyc < 0) begin
      i_req = 1'b0;
      sb.delete();
    end
    vectors++;
    if (rd_trace !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL fetch_strobe: read trace=%b, want 00000010", rd_trace);
    end
    vectors++;
    if (ack_cyc != 3 || ack_n != 1) begin
      miscompares++;
      $display("FAIL fetch_ack: cycle=%0d count=%0d, want cycle 3 count 1", ack_cyc, ack_n);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] ia[2];
    logic [31:0] da[2];
    logic [31:0] last_d;
    int acks;
    int n_i;
    int n_d;
    exp_t e;
    ia[0] = 32'h00400010; ia[1] = 32'h00400014;
    da[0] = 32'h10010003; da[1] = 32'h10010006;
    last_d = 32'h0; acks = 0; n_i = 0; n_d = 0;
    cfg_stall = 0;
    sb.push_back('{1'b1, mem_word(32'h10010000), 1'b0});
    sb.push_back('{1'b0, mem_word(32'h00400010), 1'b0});
    sb.push_back('{1'b1, mem_word(32'h10010004), 1'b0});
    sb.push_back('{1'b0, mem_word(32'h00400014), 1'b0});
    i_addr = ia[0]; d_addr = da[0]; d_write = 1'b0; d_byteenable = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        acks++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (i_ack === d_ack || d_ack !== e.is_data || (d_ack ? d_rdata : i_rdata) !== e.rdata ||
              (d_ack ? d_err : i_err) !== e.err) begin
            miscompares++;
            $display("FAIL arb_order[%0d]: i_ack=%b d_ack=%b ird=%h drd=%h, want data=%b rdata=%h",
                     acks, i_ack, d_ack, i_rdata, d_rdata, e.is_data, e.rdata);
          end
          if (i_ack && !d_ack) begin
            vectors++;
            if (d_rdata !== last_d) begin
              miscompares++;
              $display("FAIL arb_hold: d_rdata=%h during instr ack, want %h", d_rdata, last_d);
            end
          end
          if (d_ack) last_d = e.rdata;
        end
        if (d_ack) begin
          n_d++;
          if (n_d == 1) d_addr = da[1]; else d_req = 1'b0;
        end
        if (i_ack) begin
          n_i++;
          if (n_i == 1) i_addr = ia[1]; else i_req = 1'b0;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (acks != 4 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL arb_count: acks=%0d left=%0d, want 4 0", acks, sb.size());
    end
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_store();
    int first;
    int strobes;
    int ack_cyc;
    exp_t e;
    first = -1; strobes = 0; ack_cyc = -1;
    cfg_stall = 3;
    d_addr = 32'h00000013; d_byteenable = 4'b0011; d_wdata = 32'hDEADBEEF; d_write = 1'b1;
    d_req = 1'b1;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL store_busy: busy=%b, want 1", busy);
        end
      end
      if (avm_write || avm_read) begin
        strobes++;
        if (first < 0) first = c;
        vectors++;
        if (avm_address !== 32'h00000010 || avm_byteenable !== 4'b0011 ||
            avm_writedata !== 32'hDEADBEEF || avm_read !== 1'b0) begin
          miscompares++;
          $display("FAIL store_bus[%0d]: addr=%h be=%b wd=%h rd=%b, want 00000010 0011 deadbeef 0",
                   c, avm_address, avm_byteenable, avm_writedata, avm_read);
        end
      end
      if (d_ack && ack_cyc < 0) begin
        ack_cyc = c;
        d_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (i_ack !== 1'b0 || d_rdata !== e.rdata || d_err !== e.err) begin
            miscompares++;
            $display("FAIL store_result: i_ack=%b rdata=%h err=%b, want 0 %h %b", i_ack, d_rdata, d_err, e.rdata, e.err);
          end
        end
      end
    end
    d_req = 1'b0; d_write = 1'b0;
    sb.delete();
    vectors++;
    if (first != 1 || strobes != 4 || ack_cyc != 5) begin
      miscompares++;
      $display("FAIL store_timing: first=%0d strobes=%0d ack=%0d, want 1 4 5", first, strobes, ack_cyc);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] rd_trace;
    int ack_cyc;
    exp_t e;
    rd_trace = '0; ack_cyc = -1;
    cfg_stall = 1000;
    i_addr = 32'h00400020;
    i_req = 1'b1;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      rd_trace[c] = avm_read;
      if (c == ack_cyc + 1 && ack_cyc > 0) begin
        vectors++;
        if (busy !== 1'b0 || i_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_idle: busy=%b i_ack=%b, want 0 0", busy, i_ack);
        end
      end
      if (i_ack && ack_cyc < 0) begin
        ack_cyc = c;
        i_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (d_ack !== 1'b0 || i_rdata !== e.rdata || i_err !== e.err) begin
            miscompares++;
            $display("FAIL timeout_result: d_ack=%b rdata=%h err=%b, want 0 %h %b", d_ack, i_rdata, i_err, e.rdata, e.err);
          end
        end
      end
    end
    i_req = 1'b0;
    sb.delete();
    vectors++;
    if (rd_trace !== 16'b0000_0000_0001_1110 || ack_cyc != 5) begin
      miscompares++;
      $display("FAIL timeout_strobe: trace=%b ack=%0d, want 0000000000011110 5", rd_trace, ack_cyc);
    end
    // Two stalls after an abort: the counter must have restarted from zero.
    cfg_stall = 2;
    ack_cyc = -1;
    i_addr = 32'h00400024;
    i_req = 1'b1;
    sb.push_back('{1'b0, mem_word(32'h00400024), 1'b0});
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (i_ack && ack_cyc < 0) begin
        ack_cyc = c;
        i_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (i_rdata !== e.rdata || i_err !== e.err) begin
            miscompares++;
            $display("FAIL timeout_recover: rdata=%h err=%b, want %h %b", i_rdata, i_err, e.rdata, e.err);
          end
        end
      end
    end
    i_req = 1'b0;
    sb.delete();
    vectors++;
    if (ack_cyc != 5) begin
      miscompares++;
      $display("FAIL timeout_recover_lat: ack=%0d, want 5", ack_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int ack_n;
    int ack_cyc;
    exp_t e;
    ack_n = 0; ack_cyc = -1;
    cfg_stall = 1000;
    i_addr = 32'h00400030;
    i_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (avm_read !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: avm_read=%b, want 1", avm_read);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_drop: avm_read=%b busy=%b i_rdata=%h, want 0 0 0", avm_read, busy, i_rdata);
    end
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cfg_stall = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) ack_n++;
    end
    vectors++;
    if (ack_n != 0) begin
      miscompares++;
      $display("FAIL rstmid_noack: %0d acks seen, want 0", ack_n);
    end
    d_addr = 32'h2000000A; d_write = 1'b0; d_byteenable = 4'hF;
    d_req = 1'b1;
    sb.push_back('{1'b1, mem_word(32'h20000008), 1'b0});
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      if (d_ack && ack_cyc < 0) begin
        ack_cyc = c;
        d_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (d_rdata !== e.rdata || d_err !== e.err || i_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_next: rdata=%h err=%b i_ack=%b, want %h %b 0", d_rdata, d_err, i_ack, e.rdata, e.err);
          end
        end
      end
    end
    d_req = 1'b0;
    sb.delete();
    vectors++;
    if (ack_cyc != 3) begin
      miscompares++;
      $display("FAIL rstmid_lat: ack=%0d, want 3", ack_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
